// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM (fetch/decode/execute/mem/wb), retire counter; `define MIPS_CTRL_ILLEGAL_TRAP_EN traps illegal ops.
// Latency: 3-5 cycles per instruction with zero-wait memory, plus one cycle per mem_ready=0 wait cycle.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready; mem_timeout flags long waits but never aborts.
module mips_multicycle_control #(
    parameter int RETIRE_W      = 16,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instruction,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                irWrite,
    output logic                pcWrite,
    output logic                branch,
    output logic                jump,
    output logic                regWrite,
    output logic                regDst,
    output logic                memToReg,
    output logic                memRead,
    output logic                memWrite,
    output logic                iorD,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [2:0]          aluControl,
    output logic [RETIRE_W-1:0] retired,
    output logic                mem_timeout
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_op
`endif
);

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int              WAIT_W     = $clog2(FETCH_TIMEOUT + 2);
    localparam bit              TIMEOUT_EN = (FETCH_TIMEOUT != 0);
    // Counter saturates at the timeout value; with timeout disabled it just parks at all-ones.
    localparam logic [WAIT_W-1:0] WAIT_SAT = TIMEOUT_EN ? WAIT_W'(FETCH_TIMEOUT) : {WAIT_W{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_MEM_ADDR, S_MEM_READ,
        S_MEM_WB, S_MEM_WRITE, S_BEQ, S_JUMP, S_ADDI_EXEC, S_ADDI_WB, S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        opcode_q, funct_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              retire;
    logic              unused_inputs;

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'd32:   return ALU_ADD;
            6'd34:   return ALU_SUB;
            6'd36:   return ALU_AND;
            6'd37:   return ALU_OR;
            6'd42:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic funct_known(input logic [5:0] f);
        return (f == 6'd32) || (f == 6'd34) || (f == 6'd36) || (f == 6'd37) || (f == 6'd42);
    endfunction

    always_comb begin
        state_d    = state_q;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        regWrite   = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        iorD       = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        aluControl = ALU_AND;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                memRead    = 1'b1;
                aluSrcB    = 2'b01;
                aluControl = ALU_ADD;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
                case (opcode_q)
                    OP_R:         state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_R_EXEC: begin
                aluSrcA    = 1'b1;
                aluControl = funct_alu(funct_q);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                state_d    = funct_known(funct_q) ? S_R_WB : S_TRAP;
`else
                state_d    = S_R_WB;
`endif
            end
            S_R_WB: begin
                regWrite   = 1'b1;
                regDst     = 1'b1;
                aluControl = funct_alu(funct_q);
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
                state_d    = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BEQ: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_SUB;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcWrite = 1'b1;
                jump    = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDI_EXEC: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
                state_d    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE))
                     && !mem_ready;
    // Staying in FETCH while waiting is not a retirement; only arrivals from a real instruction count.
    assign retire  = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            opcode_q    <= '0;
            funct_q     <= '0;
            retired     <= '0;
            mem_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_FETCH) && mem_ready) begin
                opcode_q <= instruction[31:26];
                funct_q  <= instruction[5:0];
            end
            if (retire) retired <= retired + 1'b1;
            if (waiting) begin
                if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
                if (TIMEOUT_EN && ((wait_cnt + 1'b1) == WAIT_SAT)) mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op = (state_q == S_TRAP);
`endif

    assign unused_inputs = ^{zero, instruction[25:6]};

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench: per-instruction expected control-step sequences compared cycle by cycle against the FSM.
module tb_mips_multicycle_control;
    localparam int RW  = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          reset, mem_ready, zero;
    logic [31:0]   instruction;
    logic          irWrite, pcWrite, branch, jump, regWrite, regDst, memToReg;
    logic          memRead, memWrite, iorD, aluSrcA;
    logic [1:0]    aluSrcB;
    logic [2:0]    aluControl;
    logic [RW-1:0] retired;
    logic          mem_timeout;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic          illegal_op;
`endif

    always #5 clk = ~clk;

    mips_multicycle_control #(.RETIRE_W(RW), .FETCH_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready), .zero(zero),
        .irWrite(irWrite), .pcWrite(pcWrite), .branch(branch), .jump(jump), .regWrite(regWrite),
        .regDst(regDst), .memToReg(memToReg), .memRead(memRead), .memWrite(memWrite), .iorD(iorD),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl), .retired(retired),
        .mem_timeout(mem_timeout)
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    logic [15:0] ctl;
    assign ctl = {irWrite, pcWrite, branch, jump, regWrite, regDst, memToReg, memRead,
                  memWrite, iorD, aluSrcA, aluSrcB, aluControl};

    int n_checks = 0;
    int n_pass   = 0;
    int retired_exp = 0;
    bit tmo_exp  = 1'b0;
    int wait_run = 0;

    // Expected plan: control vector, mem_ready to drive, wait-capable state, instruction valid.
    logic [15:0] pv[$];
    bit          pr[$];
    bit          pw[$];
    bit          pf[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [15:0] cv(input bit ir, pc, br, jp, rw, rd, m2r, mr, mw, io, sa,
                                        input logic [1:0] sb, input logic [2:0] alu);
        return {ir, pc, br, jp, rw, rd, m2r, mr, mw, io, sa, sb, alu};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd42:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    task automatic push(input logic [15:0] v, input bit rdy, input bit wt, input bit fe);
        pv.push_back(v); pr.push_back(rdy); pw.push_back(wt); pf.push_back(fe);
    endtask

    function automatic bit rnd();
        return 1'($urandom);
    endfunction

    task automatic build_plan(input logic [31:0] instr, input int fw, input int mw, output bit ret);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        ret = 1'b1;
        pv.delete(); pr.delete(); pw.delete(); pf.delete();
        for (int i = 0; i < fw; i++) push(cv(0,0,0,0,0,0,0,1,0,0,0,2'b01,3'b010), 1'b0, 1'b1, 1'b0);
        push(cv(1,1,0,0,0,0,0,1,0,0,0,2'b01,3'b010), 1'b1, 1'b1, 1'b1);
        push(cv(0,0,0,0,0,0,0,0,0,0,0,2'b10,3'b010), rnd(), 1'b0, 1'b0);
        case (op)
            6'd0: begin
                push(cv(0,0,0,0,0,0,0,0,0,0,1,2'b00,alu_of(fn)), rnd(), 1'b0, 1'b0);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                if (!(fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42})) begin ret = 1'b0; return; end
`endif
                push(cv(0,0,0,0,1,1,0,0,0,0,0,2'b00,alu_of(fn)), rnd(), 1'b0, 1'b0);
            end
            6'd35: begin
                push(cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,3'b010), rnd(), 1'b0, 1'b0);
                for (int i = 0; i < mw; i++) push(cv(0,0,0,0,0,0,0,1,0,1,0,2'b00,3'b000), 1'b0, 1'b1, 1'b0);
                push(cv(0,0,0,0,0,0,0,1,0,1,0,2'b00,3'b000), 1'b1, 1'b1, 1'b0);
                push(cv(0,0,0,0,1,0,1,0,0,0,0,2'b00,3'b000), rnd(), 1'b0, 1'b0);
            end
            6'd43: begin
                push(cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,3'b010), rnd(), 1'b0, 1'b0);
                for (int i = 0; i < mw; i++) push(cv(0,0,0,0,0,0,0,0,1,1,0,2'b00,3'b000), 1'b0, 1'b1, 1'b0);
                push(cv(0,0,0,0,0,0,0,0,1,1,0,2'b00,3'b000), 1'b1, 1'b1, 1'b0);
            end
            6'd4: push(cv(0,0,1,0,0,0,0,0,0,0,1,2'b00,3'b110), rnd(), 1'b0, 1'b0);
            6'd2: push(cv(0,1,0,1,0,0,0,0,0,0,0,2'b00,3'b000), rnd(), 1'b0, 1'b0);
            6'd8: begin
                push(cv(0,0,0,0,0,0,0,0,0,0,1,2'b10,3'b010), rnd(), 1'b0, 1'b0);
                push(cv(0,0,0,0,1,0,0,0,0,0,0,2'b00,3'b000), rnd(), 1'b0, 1'b0);
            end
            default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                ret = 1'b0;
`endif
            end
        endcase
    endtask

    task automatic idle_cycle();
        mem_ready = rnd(); instruction = $urandom; zero = rnd();
        @(negedge clk);
        chk("idle_ctl", 32'(ctl), 32'h0);
        chk("idle_retired", 32'(retired), 32'(retired_exp));
        chk("idle_timeout", 32'(mem_timeout), 32'(tmo_exp));
        wait_run = 0;
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input int abort_at);
        bit ret;
        build_plan(instr, fw, mw, ret);
        for (int k = 0; k < pv.size(); k++) begin
            mem_ready   = pr[k];
            instruction = pf[k] ? instr : $urandom;
            zero        = rnd();
            @(negedge clk);
            if (k == 0) chk("retired", 32'(retired), 32'(retired_exp));
            chk("ctl", 32'(ctl), 32'(pv[k]));
            chk("mem_timeout", 32'(mem_timeout), 32'(tmo_exp));
            if (pw[k] && !pr[k]) begin
                wait_run++;
                if (wait_run >= TMO) tmo_exp = 1'b1;
            end else begin
                wait_run = 0;
            end
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                retired_exp = 0; tmo_exp = 1'b0; wait_run = 0;
                return;
            end
            @(posedge clk); #1;
        end
        if (ret) retired_exp = (retired_exp + 1) % (1 << RW);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        int          pick;
        logic [5:0]  fl[5];
        fl[0] = 6'd32; fl[1] = 6'd34; fl[2] = 6'd36; fl[3] = 6'd37; fl[4] = 6'd42;
        w    = $urandom;
        pick = $urandom_range(0, 6);
        case (pick)
            0: begin
                op = 6'd0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                w[5:0] = fl[$urandom_range(0, 4)];
`else
                if ($urandom_range(0, 3) != 0) w[5:0] = fl[$urandom_range(0, 4)];
`endif
            end
            1: op = 6'd35;
            2: op = 6'd43;
            3: op = 6'd4;
            4: op = 6'd2;
            5: op = 6'd8;
            default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                op = 6'd8;
`else
                op = 6'($urandom);
                while (op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43}) op = 6'($urandom);
`endif
            end
        endcase
        w[31:26] = op;
        return w;
    endfunction

    initial begin
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; instruction = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle_cycle();

        run_instr(32'h00221820, 0, 0, -1);   // add
        run_instr(32'h00853022, 0, 0, -1);   // sub
        run_instr(32'h00613824, 0, 0, -1);   // and
        run_instr(32'h00A44025, 0, 0, -1);   // or
        run_instr(32'h8C240004, 0, 3, -1);   // lw, 3 wait cycles
        run_instr(32'hAC250008, 0, 0, -1);   // sw
        run_instr(32'h0800000A, 0, 0, -1);   // j
        run_instr(32'h1043FFFE, 1, 0, -1);   // beq
        run_instr(32'h2022FFFF, 0, 0, -1);   // addi
        run_instr(32'h0022182A, 2, 0, -1);   // slt
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
        run_instr(32'hFC000000, 0, 0, -1);   // unknown opcode retires as NOP
        run_instr(32'h0022183F, 0, 0, -1);   // unlisted funct executes as add
`endif
        run_instr(32'h00221820, 20, 0, -1);  // long fetch stall trips the sticky timeout
        run_instr(32'h00221820, 0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            int fw;
            int mw;
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            run_instr(rand_instr(), fw, mw, -1);
        end

        // sw with wait states, reset asserted in its second MEM_WRITE cycle
        run_instr(32'hAC250008, 0, 3, 4);
        idle_cycle();
        run_instr(32'h8C240004, 0, 0, -1);
        run_instr(32'h00853022, 0, 0, -1);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        run_instr(32'hFC000000, 0, 0, -1);
        for (int i = 0; i < 3; i++) begin
            mem_ready = rnd(); instruction = $urandom;
            @(negedge clk);
            chk("trap_ctl", 32'(ctl), 32'h0);
            chk("trap_illegal_op", 32'(illegal_op), 32'h1);
            chk("trap_retired", 32'(retired), 32'(retired_exp));
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        retired_exp = 0; tmo_exp = 1'b0;
        @(negedge clk);
        chk("trap_cleared", 32'(illegal_op), 32'h0);
        @(posedge clk); #1;
`endif

        mem_ready = 1'b0;
        @(negedge clk);
        chk("final_retired", 32'(retired), 32'(retired_exp));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
